// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pll_reset_sequencer
// Brief  : Pulses the PLL reset, qualifies lock (timeout + debounce), then
//          releases three domain resets in staggered order. Optional macro
//          PLLSEQ_LOSS_CNT_EN adds a saturating lock-loss counter (loss_cnt).
// Rev    : 1.0
// ============================================================================
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int STAGGER       = 8,
    parameter int MAX_RETRIES   = 4
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       req_relock,
    output logic       pll_rst,
    output logic [2:0] dom_reset,
    output logic       ready,
    output logic       fail,
`ifdef PLLSEQ_LOSS_CNT_EN
    output logic [7:0] loss_cnt,
`endif
    output logic [3:0] retry_cnt
);

    localparam int C_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int C_MAX_B = (STABLE_CYCLES > 2 * STAGGER) ? STABLE_CYCLES : 2 * STAGGER;
    localparam int C_MAX   = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
    localparam int C_CNT_W = $clog2(C_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_RST_LAST = C_CNT_W'(RST_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_TMO_LAST = C_CNT_W'(LOCK_TIMEOUT - 1);
    // The S_WAIT cycle that first sees lock counts toward the debounce window.
    localparam logic [C_CNT_W-1:0] C_STB_LAST = C_CNT_W'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
    localparam logic [C_CNT_W-1:0] C_STAG_1   = C_CNT_W'(STAGGER);
    localparam logic [C_CNT_W-1:0] C_REL_LAST = C_CNT_W'(2 * STAGGER - 1);

    typedef enum logic [2:0] {
        S_PLLRST  = 3'd0,
        S_WAIT    = 3'd1,
        S_STABLE  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         retry_q, retry_d;
    logic [1:0]         sync_q;
    logic               locked_s;
    logic [3:0]         retry_inc;
    logic               budget_spent;
`ifdef PLLSEQ_LOSS_CNT_EN
    logic [7:0]         loss_q, loss_d;
`endif

    assign locked_s     = sync_q[1];
    assign retry_inc    = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
    assign budget_spent = (MAX_RETRIES != 0) && ({28'd0, retry_inc} >= 32'(MAX_RETRIES));
    assign retry_cnt    = retry_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= S_PLLRST;
            cnt_q   <= '0;
            retry_q <= '0;
            sync_q  <= '0;
`ifdef PLLSEQ_LOSS_CNT_EN
            loss_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            sync_q  <= {sync_q[0], pll_locked};
`ifdef PLLSEQ_LOSS_CNT_EN
            loss_q  <= loss_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + C_CNT_W'(1);
        retry_d   = retry_q;
        pll_rst   = 1'b0;
        dom_reset = 3'b111;
        ready     = 1'b0;
        fail      = 1'b0;
`ifdef PLLSEQ_LOSS_CNT_EN
        loss_d    = loss_q;
`endif
        case (state_q)
            S_PLLRST: begin
                pll_rst = 1'b1;
                if (cnt_q == C_RST_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (req_relock) begin
                    state_d = S_PLLRST;
                    cnt_d   = '0;
                end else if (locked_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_TMO_LAST) begin
                    retry_d = retry_inc;
                    state_d = budget_spent ? S_FAIL : S_PLLRST;
                    cnt_d   = '0;
                end
            end
            S_STABLE: begin
                if (req_relock) begin
                    state_d = S_PLLRST;
                    cnt_d   = '0;
                end else if (!locked_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q >= C_STB_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            end
            S_RELEASE: begin
                // Domain 2 is released on entry to S_RUN, together with ready.
                dom_reset = {1'b1, (cnt_q < C_STAG_1), 1'b0};
                if (req_relock || !locked_s) begin
                    state_d = S_PLLRST;
                    cnt_d   = '0;
                end else if (cnt_q == C_REL_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                dom_reset = 3'b000;
                ready     = 1'b1;
                cnt_d     = cnt_q;
                if (!locked_s || req_relock) begin
                    state_d = S_PLLRST;
                    cnt_d   = '0;
`ifdef PLLSEQ_LOSS_CNT_EN
                    if (!locked_s && (loss_q != 8'hFF)) begin
                        loss_d = loss_q + 8'd1;
                    end
`endif
                end
            end
            S_FAIL: begin
                pll_rst = 1'b1;
                fail    = 1'b1;
                cnt_d   = cnt_q;
                if (req_relock) begin
                    state_d = S_PLLRST;
                    retry_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_PLLRST;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef PLLSEQ_LOSS_CNT_EN
    assign loss_cnt = loss_q;
`endif

endmodule
`default_nettype wire
